// File: rtl/intersection_phase_scheduler.sv
// Timed phase scheduler for a two-street intersection with a pedestrian
// crossing. It sequences green/yellow/all-red phases for streets A and B,
// inserts a walk phase on request, and supports a parade latch that pins
// street B green.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 12,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 6,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TA,
    input  logic       TB,
    input  logic       P,
    input  logic       R,
    input  logic       ped_req,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic       M,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_CLEAR  = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_CLEAR  = 3'd5,
        WALK     = 3'd6
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    // Timer thresholds are "last cycle" values, since cnt starts at 0.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WLK_LAST = CNT_W'(WALK_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             last_dir, last_dir_nx;   // 0 = A cleared last, 1 = B
    logic             entering_walk;

    // Next-state selection from the current phase, timer and requests.
    always_comb begin
        state_nx    = state;
        last_dir_nx = last_dir;
        case (state)
            A_GREEN:
                if (cnt >= MIN_LAST &&
                    (!TA || (cnt >= MAX_LAST && (TB || ped_pending))))
                    state_nx = A_YELLOW;
            B_GREEN:
                if (!M && cnt >= MIN_LAST &&
                    (!TB || (cnt >= MAX_LAST && (TA || ped_pending))))
                    state_nx = B_YELLOW;
            A_YELLOW: if (cnt == YEL_LAST) state_nx = A_CLEAR;
            B_YELLOW: if (cnt == YEL_LAST) state_nx = B_CLEAR;
            A_CLEAR:
                if (cnt == CLR_LAST) begin
                    state_nx    = ped_pending ? WALK : B_GREEN;
                    last_dir_nx = 1'b0;
                end
            B_CLEAR:
                if (cnt == CLR_LAST) begin
                    state_nx    = ped_pending ? WALK : A_GREEN;
                    last_dir_nx = 1'b1;
                end
            WALK:
                if (cnt == WLK_LAST)
                    state_nx = last_dir ? A_GREEN : B_GREEN;
            default: state_nx = A_GREEN;   // stray code 7 recovers to A
        endcase
    end

    assign entering_walk = (state_nx == WALK) && (state != WALK);

    // State, saturating phase timer, parade and pedestrian latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= A_GREEN;
            cnt         <= '0;
            M           <= 1'b0;
            ped_pending <= 1'b0;
            last_dir    <= 1'b0;
        end else begin
            state    <= state_nx;
            last_dir <= last_dir_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
            // R dominates P so a stuck start can always be cancelled.
            M <= R ? 1'b0 : (P ? 1'b1 : M);
            // The walk entry edge consumes the request, including one
            // arriving in that same cycle.
            if (entering_walk)
                ped_pending <= 1'b0;
            else if (state != WALK && ped_req)
                ped_pending <= 1'b1;
        end
    end

    // Moore lamp decode; anything not explicitly green/yellow is red.
    always_comb begin
        LA   = L_RED;
        LB   = L_RED;
        walk = 1'b0;
        case (state)
            A_GREEN:  LA = L_GREEN;
            A_YELLOW: LA = L_YELLOW;
            B_GREEN:  LB = L_GREEN;
            B_YELLOW: LB = L_YELLOW;
            WALK:     walk = 1'b1;
            default:  ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus a random
// run, all compared against a phase-level reference model.
module tb_intersection_phase_scheduler;

    localparam int MIN_GREEN  = 4;
    localparam int MAX_GREEN  = 12;
    localparam int YELLOW_CYC = 2;
    localparam int ALLRED_CYC = 1;
    localparam int WALK_CYC   = 6;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic TA = 1'b0, TB = 1'b0, P = 1'b0, R = 1'b0, ped_req = 1'b0;
    logic [1:0] LA, LB;
    logic walk, M, ped_pending;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    intersection_phase_scheduler #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC), .WALK_CYC(WALK_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .TA(TA), .TB(TB), .P(P), .R(R),
        .ped_req(ped_req), .LA(LA), .LB(LB), .walk(walk), .M(M),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: phase name, cycles spent in it (unbounded), latches.
    // Phase numbers: 0 AG, 1 AY, 2 AC, 3 BG, 4 BY, 5 BC, 6 WALK.
    int m_ph = 0, m_el = 0;
    bit m_M = 0, m_ped = 0, m_lastb = 0;

    logic [9:0] dut_vec;
    assign dut_vec = {phase, LA, LB, walk, M, ped_pending};

    function automatic logic [1:0] lamp_a(int p);
        if (p == 0) return 2'b00;
        if (p == 1) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] lamp_b(int p);
        if (p == 3) return 2'b00;
        if (p == 4) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [9:0] exp_vec();
        return {3'(m_ph), lamp_a(m_ph), lamp_b(m_ph), (m_ph == 6), m_M, m_ped};
    endfunction

    task automatic model_step();
        int np;
        if (rst) begin
            m_ph = 0; m_el = 0; m_M = 0; m_ped = 0; m_lastb = 0;
            return;
        end
        np = m_ph;
        case (m_ph)
            0: if (m_el + 1 >= MIN_GREEN &&
                   (!TA || (m_el + 1 >= MAX_GREEN && (TB || m_ped)))) np = 1;
            3: if (!m_M && m_el + 1 >= MIN_GREEN &&
                   (!TB || (m_el + 1 >= MAX_GREEN && (TA || m_ped)))) np = 4;
            1: if (m_el + 1 == YELLOW_CYC) np = 2;
            4: if (m_el + 1 == YELLOW_CYC) np = 5;
            2: if (m_el + 1 == ALLRED_CYC) begin np = m_ped ? 6 : 3; m_lastb = 0; end
            5: if (m_el + 1 == ALLRED_CYC) begin np = m_ped ? 6 : 0; m_lastb = 1; end
            6: if (m_el + 1 == WALK_CYC) np = m_lastb ? 0 : 3;
            default: np = 0;
        endcase
        if (np == 6 && m_ph != 6) m_ped = 0;
        else if (m_ph != 6 && ped_req) m_ped = 1;
        m_M  = R ? 1'b0 : (P ? 1'b1 : m_M);
        m_el = (np != m_ph) ? 0 : m_el + 1;
        m_ph = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Two reset edges; returns observing cycle 0 with rst released.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        TA = 1; TB = 1; P = 1; ped_req = 1;
        do_reset();
        P = 0; ped_req = 0;
        total++;
        if (dut_vec !== 10'b000_00_10_0_0_0) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 10'b000_00_10_0_0_0);
        end
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec());
        end
        tick();
        total++;
        if (phase !== 3'd0 || M !== 1'b0) begin
            bad++; $display("FAIL reset_hold phase=%0d M=%b exp phase=0 M=0", phase, M);
        end
    endtask

    task automatic test_a_to_b();
        int ep;
        TA = 0; TB = 1;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) tick();
            ep = (c <= 3) ? 0 : (c <= 5) ? 1 : (c == 6) ? 2 : 3;
            total++;
            if (phase !== 3'(ep) || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL a_to_b cyc=%0d got=%b exp_phase=%0d exp=%b", c, dut_vec, ep, exp_vec());
            end
        end
    endtask

    task automatic test_alternate();
        int ep, p;
        TA = 1; TB = 1;
        do_reset();
        for (int c = 0; c <= 64; c++) begin
            if (c > 0) tick();
            p  = c % 30;
            ep = (p < 12) ? 0 : (p < 14) ? 1 : (p < 15) ? 2 :
                 (p < 27) ? 3 : (p < 29) ? 4 : 5;
            total++;
            if (phase !== 3'(ep) || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL alternate cyc=%0d got=%b exp_phase=%0d exp=%b", c, dut_vec, ep, exp_vec());
            end
        end
        TB = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            total++;
            if (phase !== 3'd0 || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL a_hold step=%0d phase=%0d exp=0", c, phase);
            end
        end
    endtask

    task automatic test_ped();
        int ep;
        bit epend;
        TA = 0; TB = 0;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            ped_req = (k == 1 || k == 9);
            tick();
            ep = (k + 1 <= 3) ? 0 : (k + 1 <= 5) ? 1 : (k + 1 == 6) ? 2 :
                 (k + 1 <= 12) ? 6 : 3;
            epend = (k + 1 >= 2 && k + 1 <= 6);
            total++;
            if (phase !== 3'(ep) || ped_pending !== epend || walk !== (ep == 6) ||
                dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL ped cyc=%0d phase=%0d pend=%b walk=%b exp phase=%0d pend=%b",
                         k + 1, phase, ped_pending, walk, ep, epend);
            end
        end
        ped_req = 0;
    endtask

    task automatic test_parade();
        TA = 0; TB = 0; P = 1;
        do_reset();
        for (int c = 1; c <= 45; c++) begin
            tick();
            P = 0;
            if (c == 7) TA = 1;
            if (c >= 7) begin
                total++;
                if (phase !== 3'd3 || M !== 1'b1 || dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL parade_hold cyc=%0d phase=%0d M=%b exp phase=3 M=1", c, phase, M);
                end
            end
        end
        R = 1;
        tick();
        R = 0;
        total++;
        if (M !== 1'b0 || phase !== 3'd3) begin
            bad++; $display("FAIL parade_end phase=%0d M=%b exp phase=3 M=0", phase, M);
        end
        tick();
        total++;
        if (phase !== 3'd4 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL parade_yellow phase=%0d exp=4", phase);
        end
        P = 1; R = 1;
        tick();
        P = 0; R = 0;
        total++;
        if (M !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL parade_p_and_r M=%b exp=0", M);
        end
    endtask

    task automatic test_reset_walk();
        TA = 0; TB = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ped_req = (k == 1 || k == 8);
            tick();
        end
        total++;
        if (phase !== 3'd6 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL walk_reach phase=%0d exp=6", phase);
        end
        rst = 1; ped_req = 1;
        tick();
        rst = 0; ped_req = 0; TB = 1;
        total++;
        if (phase !== 3'd0 || walk !== 1'b0 || ped_pending !== 1'b0 || LA !== 2'b00) begin
            bad++;
            $display("FAIL walk_reset phase=%0d walk=%b pend=%b LA=%b exp 0/0/0/00",
                     phase, walk, ped_pending, LA);
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            total++;
            if (phase !== ((c <= 3) ? 3'd0 : (c <= 5) ? 3'd1 : (c == 6) ? 3'd2 : 3'd3) ||
                dut_vec !== exp_vec()) begin
                bad++; $display("FAIL walk_resume cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            TA      = ($urandom_range(0, 3) != 0);
            TB      = ($urandom_range(0, 3) != 0);
            P       = ($urandom_range(0, 39) == 0);
            R       = ($urandom_range(0, 39) == 0);
            ped_req = ($urandom_range(0, 14) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
        rst = 0; P = 0; R = 0; ped_req = 0;
    endtask

    initial begin
        test_reset();
        test_a_to_b();
        test_alternate();
        test_ped();
        test_parade();
        test_reset_walk();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
